rv32i_fetch_unit: RTL and testbench
===================================

Name: rv32i_fetch_unit

Overview:
Parametrised instruction-fetch front end for the RV32I core. It replaces the single-cycle PC register and next-PC mux with a decoupled fetch pipeline. The block owns the PC and issues requests to instruction memory over a valid/response interface, tolerating any memory latency. Fetched {pc, inst} pairs are buffered in a small FIFO and delivered to decode over a valid/ready handshake, and the block accepts JAL/branch/JALR redirects with flush.

Parameters:
XLEN, 32, datapath/PC width (≥ IMEM_AW+2)
IMEM_AW, 12, instruction memory word-address width
RESET_PC, 32'h0000_0000, PC fetched first after reset (word aligned)
FETCH_DEPTH, 2, fetch buffer entries (power of 2, ≥ 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  request valid; memory accepts every asserted cycle
imem_addr  out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]
imem_rvalid  in  1  response valid; in order; at most one in flight
imem_rdata  in  32  instruction word
inst_valid  out  1  buffered instruction available
inst_ready  in  1  decode accepts
inst  out  32  instruction at FIFO head
inst_pc  out  XLEN  PC of that instruction
redir_valid  in  1  redirect request from execute
redir_sel  in  2  01 JAL, 10 branch, 11 JALR, 00 ignored
br_taken  in  1  branch outcome; used only when redir_sel = 10
jal_tgt  in  XLEN  JAL target (PC + J-imm)
br_tgt  in  XLEN  branch target (PC + B-imm)
jalr_base  in  XLEN  rs1 value
jalr_imm  in  XLEN  sign-extended I-imm
fetch_err  out  1  misaligned-target trap (feature only; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync release): fetch_pc = RESET_PC. FIFO is empty, no request is outstanding, and the squash flag is 0. imem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_err=0. State = IDLE.
- States:
  - IDLE -> REQ on the first clock after reset release.
  - REQ: imem_req=1 if (fifo_count + 0) < FETCH_DEPTH, i.e. space for the returning word. On issue, record req_pc = fetch_pc and go to WAIT. Otherwise hold in REQ (stall).
  - WAIT: imem_req=0. On imem_rvalid, if squash=0, push {req_pc, imem_rdata} and set fetch_pc = req_pc + 4. If squash=1, drop the word and clear squash. In both cases go to REQ.
- Back-to-back: from REQ to WAIT to REQ, so peak throughput is one instruction per 2 cycles with 1-cycle memory latency. With 1-cycle latency, the first inst_valid is asserted 3 cycles after reset release.
- Output path: inst/inst_pc/inst_valid come from the registered FIFO head. A pop occurs when inst_valid && inst_ready.
- Redirect effective: redir_valid && (sel=01 || sel=11 || (sel=10 && br_taken)).
- Target selection:
  - JAL: jal_tgt.
  - Branch: br_tgt.
  - JALR: (jalr_base + jalr_imm) with bit0 cleared. The add is XLEN-bit and wraps modulo 2^XLEN.
- Effective redirect actions:
  - Flush the FIFO, so inst_valid=0 the next cycle.
  - Set fetch_pc = target.
  - If in WAIT with no rvalid this cycle, set squash=1.
  - If rvalid arrives the same cycle, discard that word and do not set squash.
  - Next state is REQ; the first request at the target is issued the cycle after the redirect.
- Simultaneous pop and redirect: the pop completes (decode consumed the head), then the flush clears the rest.
- A redirect while in IDLE or during reset is ignored.
- FIFO full: no new request is issued, and the outstanding word is guaranteed a slot.
- FIFO empty: inst_valid=0, and inst/inst_pc hold their last values.
- fetch_pc wraps modulo 2^XLEN. imem_addr uses only bits [IMEM_AW+1:2], so it wraps within memory.
- Without the feature, target bits [1:0] are forced to 00.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined: an effective redirect whose target[1:0] != 00 sets fetch_err=1 (sticky) and flushes as normal. The FIFO is left empty and no further requests are issued (state IDLE). A later aligned effective redirect clears fetch_err and resumes fetch at that target.
- When undefined: fetch_err is tied to 0 and targets are silently force-aligned.

Test Plan:
- Reset, 1-cycle memory returning addr-encoded words, inst_ready=1 -> imem_addr 0,1,2,3…; inst_pc 0x0,0x4,0x8 with matching inst; first inst_valid 3 cycles after rst_n rises.
- inst_ready=0 for 10 cycles -> exactly FETCH_DEPTH=2 entries buffered and imem_req stays 0. Then ready=1 -> pcs 0x0,0x4,0x8 delivered with no gap or duplicate.
- JAL redirect to 0x100 while a request is outstanding (3-cycle latency) -> stale word dropped; next inst_pc=0x100 and the FIFO was flushed.
- Branch sel=10 with br_taken=0 -> no flush, sequence continues. With br_taken=1 and br_tgt=0x40 -> next inst_pc=0x40.
- JALR base=0x203, imm=0xFFFF_FFFE -> target 0x200 (bit0 cleared, 0x201 -> 0x200); inst_pc=0x200.
- With FETCH_MISALIGN_TRAP_EN: JAL to 0x102 -> fetch_err=1, imem_req=0. JAL to 0x104 -> fetch_err=0, inst_pc=0x104. Assert rst_n=0 mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rv32i_fetch_unit.sv
// Decoupled RV32I instruction fetch: owns the PC, issues one imem request at a time,
// buffers {pc, inst} pairs in a small FIFO and applies JAL/branch/JALR redirects with flush.
// Optional misaligned-target trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module rv32i_fetch_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     IMEM_AW     = 12,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     FETCH_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [31:0]        imem_rdata_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [31:0]        inst_o,
    output logic [XLEN-1:0]    inst_pc_o,
    input  logic               redir_valid_i,
    input  logic [1:0]         redir_sel_i,
    input  logic               br_taken_i,
    input  logic [XLEN-1:0]    jal_tgt_i,
    input  logic [XLEN-1:0]    br_tgt_i,
    input  logic [XLEN-1:0]    jalr_base_i,
    input  logic [XLEN-1:0]    jalr_imm_i,
    output logic               fetch_err_o
);

    localparam int unsigned PTR_W = $clog2(FETCH_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            squash_q, squash_d;
    logic            imem_req_q, imem_req_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t          head_q, head_d;
    entry_t          buf_q [FETCH_DEPTH];

    logic            pop, push, take, redir_hit, redir_eff;
    logic [XLEN-1:0] jalr_sum, target;
    entry_t          push_entry;

    assign jalr_sum   = jalr_base_i + jalr_imm_i;
    assign pop        = valid_q && inst_ready_i;
    assign take       = imem_rvalid_i && !squash_q && (state_q == S_WAIT);
    assign redir_hit  = redir_valid_i && ((redir_sel_i == 2'b01) || (redir_sel_i == 2'b11) ||
                                          ((redir_sel_i == 2'b10) && br_taken_i));
    // A trapped unit sits in IDLE with err set and must still accept the recovering redirect.
    assign redir_eff  = redir_hit && ((state_q != S_IDLE) || err_q);
    assign push       = take && !redir_eff;
    assign push_entry = '{pc: req_pc_q, inst: imem_rdata_i};

    always_comb begin
        case (redir_sel_i)
            2'b10:   target = br_tgt_i;
            2'b11:   target = jalr_sum & ~XLEN'(1);
            default: target = jal_tgt_i;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        squash_d   = squash_q;
        err_d      = err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        head_d     = head_q;

        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (imem_rvalid_i && squash_q) squash_d = 1'b0;

        case (state_q)
            S_IDLE: if (!err_q) state_d = S_REQ;
            S_REQ: if (imem_req_q) begin
                state_d  = S_WAIT;
                req_pc_d = fetch_pc_q;
            end
            S_WAIT: if (take) begin
                state_d    = S_REQ;
                fetch_pc_d = req_pc_q + XLEN'(4);
            end
            default: state_d = S_IDLE;
        endcase

        if (redir_eff) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = target & ~XLEN'(3);
            state_d    = S_REQ;
            // Any request still in flight after this cycle returns a stale word.
            squash_d   = imem_req_q || (((state_q == S_WAIT) || squash_q) && !imem_rvalid_i);
`ifdef FETCH_MISALIGN_TRAP_EN
            err_d = (target[1:0] != 2'b00);
            if (err_d) state_d = S_IDLE;
`endif
        end

        if (count_d != '0)
            head_d = ((count_q == CNT_W'(pop)) && push) ? push_entry : buf_q[rd_ptr_d];

        valid_d = (count_d != '0);
        // A stale word must drain before the next request so only one is ever in flight.
        imem_req_d = (state_d == S_REQ) && (count_d < CNT_W'(FETCH_DEPTH)) && !squash_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            squash_q   <= 1'b0;
            imem_req_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            squash_q   <= squash_d;
            imem_req_q <= imem_req_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // NOTE: buffer storage is not reset; count/pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr_q] <= push_entry;
    end

    assign imem_req_o   = imem_req_q;
    assign imem_addr_o  = fetch_pc_q[IMEM_AW+1:2];
    assign inst_valid_o = valid_q;
    assign inst_o       = head_q.inst;
    assign inst_pc_o    = head_q.pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_err_o  = err_q;
`else
    assign fetch_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed self-checking bench for rv32i_fetch_unit with a single-outstanding,
// fixed-latency instruction memory that returns 0xC000_0000 | word address.
module tb_rv32i_fetch_unit;

    localparam int XLEN    = 32;
    localparam int IMEM_AW = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               imem_req, imem_rvalid = 1'b0, inst_valid, inst_ready = 1'b0;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata = '0, inst;
    logic [XLEN-1:0]    inst_pc;
    logic               redir_valid = 1'b0, br_taken = 1'b0, fetch_err;
    logic [1:0]         redir_sel = 2'b00;
    logic [XLEN-1:0]    jal_tgt = '0, br_tgt = '0, jalr_base = '0, jalr_imm = '0;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int timer  = 0;
    logic [IMEM_AW-1:0] pend_addr = '0;
    logic [63:0]        deliv_q[$];
    logic [IMEM_AW-1:0] req_addrs[$];

    always #5 clk = ~clk;

    rv32i_fetch_unit #(.XLEN(XLEN), .IMEM_AW(IMEM_AW), .RESET_PC(32'h0), .FETCH_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
        .inst_o(inst), .inst_pc_o(inst_pc),
        .redir_valid_i(redir_valid), .redir_sel_i(redir_sel), .br_taken_i(br_taken),
        .jal_tgt_i(jal_tgt), .br_tgt_i(br_tgt), .jalr_base_i(jalr_base), .jalr_imm_i(jalr_imm),
        .fetch_err_o(fetch_err)
    );

    function automatic logic [63:0] exp_item(input logic [31:0] pc);
        return {pc, 32'hC000_0000 | {20'h0, pc[13:2]}};
    endfunction

    // Memory model and delivery monitor, both working mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            imem_rvalid = 1'b0;
            timer = 0;
        end else begin
            imem_rvalid = 1'b0;
            if (timer != 0) begin
                timer = timer - 1;
                if (timer == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = 32'hC000_0000 | {20'h0, pend_addr};
                end
            end
            if (imem_req) begin
                checks++;
                if (timer != 0 || imem_rvalid) begin
                    errors++;
                    $display("FAIL protocol: request at addr %h while one in flight (timer %0d)", imem_addr, timer);
                end
                req_addrs.push_back(imem_addr);
                pend_addr = imem_addr;
                timer = lat;
            end
            if (inst_valid && inst_ready) deliv_q.push_back({inst_pc, inst});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst_n = 1'b0; inst_ready = 1'b0; redir_valid = 1'b0; redir_sel = 2'b00; br_taken = 1'b0;
        jal_tgt = '0; br_tgt = '0; jalr_base = '0; jalr_imm = '0; lat = l;
        step(); step();
        deliv_q.delete(); req_addrs.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_deliv(input int n);
        int b = 0;
        while (deliv_q.size() < n && b < 300) begin step(); b++; end
        checks++;
        if (deliv_q.size() < n) begin
            errors++;
            $display("FAIL wait_deliv: got %0d deliveries, need %0d", deliv_q.size(), n);
        end
    endtask

    task automatic wait_outstanding();
        int b = 0;
        while (timer == 0 && b < 50) begin step(); b++; end
        checks++;
        if (timer == 0) begin
            errors++;
            $display("FAIL wait_outstanding: no request in flight after %0d cycles", b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inst_ready = 1'b1; lat = 1;
        redir_valid = 1'b1; redir_sel = 2'b01; jal_tgt = 32'h300;
        step(); step();
        checks += 5;
        if (imem_req !== 1'b0)   begin errors++; $display("FAIL reset imem_req: got %b exp 0", imem_req); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset inst_valid: got %b exp 0", inst_valid); end
        if (inst !== 32'h0)      begin errors++; $display("FAIL reset inst: got %h exp 0", inst); end
        if (inst_pc !== 32'h0)   begin errors++; $display("FAIL reset inst_pc: got %h exp 0", inst_pc); end
        if (fetch_err !== 1'b0)  begin errors++; $display("FAIL reset fetch_err: got %b exp 0", fetch_err); end
        rst_n = 1'b1;
        step();
        redir_valid = 1'b0;
        checks += 3;
        if (imem_req !== 1'b1)   begin errors++; $display("FAIL c1 imem_req: got %b exp 1", imem_req); end
        if (imem_addr !== '0)    begin errors++; $display("FAIL c1 imem_addr (redirect in IDLE must be ignored): got %h exp 0", imem_addr); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL c1 inst_valid: got %b exp 0", inst_valid); end
        step();
        checks += 2;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL c2 inst_valid: got %b exp 0", inst_valid); end
        if (imem_req !== 1'b0)   begin errors++; $display("FAIL c2 imem_req: got %b exp 0", imem_req); end
        step();
        checks += 2;
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL c3 inst_valid: got %b exp 1", inst_valid); end
        if ({inst_pc, inst} !== exp_item(32'h0)) begin
            errors++; $display("FAIL c3 head: got %h exp %h", {inst_pc, inst}, exp_item(32'h0));
        end
    endtask

    task automatic test_stream();
        wait_deliv(4);
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (deliv_q[i] !== exp_item(32'(4 * i))) begin
                errors++; $display("FAIL stream item %0d: got %h exp %h", i, deliv_q[i], exp_item(32'(4 * i)));
            end
            if (req_addrs[i] !== IMEM_AW'(i)) begin
                errors++; $display("FAIL stream imem_addr %0d: got %h exp %h", i, req_addrs[i], IMEM_AW'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 6) begin
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL full imem_req cycle %0d: got %b exp 0", i, imem_req); end
            end
        end
        checks += 3;
        if (req_addrs.size() != 2) begin errors++; $display("FAIL full buffered: got %0d requests exp 2", req_addrs.size()); end
        if (deliv_q.size() != 0)   begin errors++; $display("FAIL full deliveries: got %0d exp 0", deliv_q.size()); end
        if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL full head: got valid %b pc %h exp 1 / 0", inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        wait_deliv(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (deliv_q[i] !== exp_item(32'(4 * i))) begin
                errors++; $display("FAIL drain item %0d: got %h exp %h", i, deliv_q[i], exp_item(32'(4 * i)));
            end
        end
    endtask

    task automatic test_jal_redirect();
        int b = 0;
        do_reset(3);
        while (!inst_valid && b < 30) begin step(); b++; end
        wait_outstanding();
        checks++;
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL jal pre inst_valid: got %b exp 1", inst_valid); end
        redir_valid = 1'b1; redir_sel = 2'b01; jal_tgt = 32'h100;
        step();
        redir_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL jal flush inst_valid: got %b exp 0", inst_valid); end
        deliv_q.delete();
        inst_ready = 1'b1;
        wait_deliv(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (deliv_q[i] !== exp_item(32'(32'h100 + 4 * i))) begin
                errors++; $display("FAIL jal item %0d: got %h exp %h", i, deliv_q[i], exp_item(32'(32'h100 + 4 * i)));
            end
        end
    endtask

    task automatic test_branch();
        do_reset(1);
        inst_ready = 1'b1;
        wait_deliv(2);
        redir_valid = 1'b1; redir_sel = 2'b10; br_taken = 1'b0; br_tgt = 32'h40;
        step();
        redir_sel = 2'b00; br_taken = 1'b1;
        step();
        redir_valid = 1'b0;
        wait_deliv(6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (deliv_q[i] !== exp_item(32'(4 * i))) begin
                errors++; $display("FAIL not-taken item %0d: got %h exp %h", i, deliv_q[i], exp_item(32'(4 * i)));
            end
        end
        redir_valid = 1'b1; redir_sel = 2'b10; br_taken = 1'b1;
        step();
        deliv_q.delete();
        redir_valid = 1'b0;
        wait_deliv(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (deliv_q[i] !== exp_item(32'(32'h40 + 4 * i))) begin
                errors++; $display("FAIL taken item %0d: got %h exp %h", i, deliv_q[i], exp_item(32'(32'h40 + 4 * i)));
            end
        end
    endtask

    task automatic test_jalr();
        redir_valid = 1'b1; redir_sel = 2'b11; jalr_base = 32'h203; jalr_imm = 32'hFFFF_FFFE;
        step();
        deliv_q.delete();
        redir_valid = 1'b0;
        wait_deliv(1);
        checks++;
        if (deliv_q[0] !== exp_item(32'h200)) begin
            errors++; $display("FAIL jalr item: got %h exp %h", deliv_q[0], exp_item(32'h200));
        end
    endtask

    task automatic test_misaligned();
        redir_valid = 1'b1; redir_sel = 2'b01; jal_tgt = 32'h102;
        step();
        deliv_q.delete();
        redir_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (fetch_err !== 1'b1) begin errors++; $display("FAIL trap fetch_err: got %b exp 1", fetch_err); end
        repeat (6) begin
            step();
            checks += 2;
            if (imem_req !== 1'b0)   begin errors++; $display("FAIL trap imem_req: got %b exp 0", imem_req); end
            if (inst_valid !== 1'b0) begin errors++; $display("FAIL trap inst_valid: got %b exp 0", inst_valid); end
        end
        redir_valid = 1'b1; jal_tgt = 32'h104;
        step();
        redir_valid = 1'b0;
        checks++;
        if (fetch_err !== 1'b0) begin errors++; $display("FAIL recover fetch_err: got %b exp 0", fetch_err); end
        wait_deliv(1);
        checks++;
        if (deliv_q[0] !== exp_item(32'h104)) begin
            errors++; $display("FAIL recover item: got %h exp %h", deliv_q[0], exp_item(32'h104));
        end
`else
        wait_deliv(1);
        checks += 2;
        if (deliv_q[0] !== exp_item(32'h100)) begin
            errors++; $display("FAIL align item: got %h exp %h", deliv_q[0], exp_item(32'h100));
        end
        if (fetch_err !== 1'b0) begin errors++; $display("FAIL align fetch_err: got %b exp 0", fetch_err); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset(3);
        inst_ready = 1'b1;
        wait_deliv(2);
        wait_outstanding();
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (imem_req !== 1'b0)   begin errors++; $display("FAIL areset imem_req: got %b exp 0", imem_req); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL areset inst_valid: got %b exp 0", inst_valid); end
        if (inst !== 32'h0)      begin errors++; $display("FAIL areset inst: got %h exp 0", inst); end
        if (inst_pc !== 32'h0)   begin errors++; $display("FAIL areset inst_pc: got %h exp 0", inst_pc); end
        if (fetch_err !== 1'b0)  begin errors++; $display("FAIL areset fetch_err: got %b exp 0", fetch_err); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jal_redirect();
        test_branch();
        test_jalr();
        test_misaligned();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
